// File: rtl/fpu_ontest_harness.sv
// On-target stimulus harness: drives a DUT with counter/LFSR/walking-one/hold
// operands and folds the latency-aligned results into a rotate-XOR MISR.
module fpu_ontest_harness #(
  parameter int WIDTH   = 32,
  parameter int N_VEC   = 1024,
  parameter int LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [WIDTH-1:0]               seed,
  output logic [WIDTH-1:0]               op,
  output logic                           op_valid,
  input  logic [WIDTH-1:0]               dut_result,
  (* mark_debug = "true" *)
  output logic [WIDTH-1:0]               result_debug,
  output logic [WIDTH-1:0]               signature,
  output logic [$clog2(N_VEC+1)-1:0]     vec_count,
  output logic                           busy,
  output logic                           done
);

  localparam int VCW = $clog2(N_VEC + 1);

  // Right-shift Galois taps giving maximal-length sequences
  function automatic logic [63:0] poly_for(input int w);
    case (w)
      4:       poly_for = 64'hC;
      8:       poly_for = 64'hB8;
      12:      poly_for = 64'hE08;
      16:      poly_for = 64'hB400;
      24:      poly_for = 64'hE1_0000;
      32:      poly_for = 64'hA300_0000;
      64:      poly_for = 64'hD800_0000_0000_0000;
      default: poly_for = 64'd1 << (w - 1);
    endcase
  endfunction

  localparam logic [63:0]      POLY64 = poly_for(WIDTH);
  localparam logic [WIDTH-1:0] POLY   = POLY64[WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   seed_q;
  logic [VCW-1:0]     cap_cnt;
  logic               start_acc;
  logic               cap_valid;
  logic               capture;
  logic               last_issue;
  logic               last_capture;

  function automatic logic [WIDTH-1:0] init_op(input logic [1:0] m,
                                               input logic [WIDTH-1:0] s);
    case (m)
      2'd0:    init_op = s;
      2'd1:    init_op = (s == '0) ? WIDTH'(1) : s;
      2'd2:    init_op = WIDTH'(1);
      default: init_op = s;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] next_op(input logic [1:0] m,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] s);
    case (m)
      2'd0:    next_op = x + 1'b1;
      2'd1:    next_op = (x >> 1) ^ (x[0] ? POLY : '0);
      2'd2:    next_op = {x[WIDTH-2:0], x[WIDTH-1]};
      default: next_op = s;
    endcase
  endfunction

  assign start_acc    = start && ((state == IDLE) || (state == DONE));
  assign last_issue   = (vec_count == VCW'(N_VEC - 1));
  assign capture      = cap_valid && ((state == RUN) || (state == DRAIN));
  assign last_capture = capture && (cap_cnt == VCW'(N_VEC - 1));

  // Valid delay line aligning each issued vector with its DUT result
  generate
    if (LATENCY == 0) begin : g_nodly
      assign cap_valid = op_valid;
    end else begin : g_dly
      logic [LATENCY-1:0] vdly;
      always_ff @(posedge clk) begin
        if (reset || start_acc) begin
          vdly <= '0;
        end else begin
          vdly <= (vdly << 1) | LATENCY'(op_valid);
        end
      end
      assign cap_valid = vdly[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // With zero latency the last result lands in the last RUN cycle, so DRAIN is skipped
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (last_issue) state_nx = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN:      if (last_capture) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_valid = (state == RUN);
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= '0;
      seed_q       <= '0;
      op           <= '0;
      vec_count    <= '0;
      cap_cnt      <= '0;
      result_debug <= '0;
      signature    <= '0;
    end else if (start_acc) begin
      mode_q       <= mode;
      seed_q       <= seed;
      op           <= init_op(mode, seed);
      vec_count    <= '0;
      cap_cnt      <= '0;
      result_debug <= '0;
      signature    <= '0;
    end else begin
      if (op_valid) begin
        vec_count <= vec_count + 1'b1;
        if (!last_issue) begin
          op <= next_op(mode_q, op, seed_q);
        end
      end
      if (capture) begin
        result_debug <= dut_result;
        signature    <= {signature[WIDTH-2:0], signature[WIDTH-1]} ^ dut_result;
        cap_cnt      <= cap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fpu_ontest_harness.md
FPU_ONTEST_HARNESS -- requirements
Module: fpu_ontest_harness

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the width of DUT operand and result.
REQ-002 The block SHALL have parameter N_VEC, default 1024, giving the number of vectors per run (>=1).
REQ-003 The block SHALL have parameter LATENCY, default 1, giving the DUT pipeline depth in cycles (>=0).
REQ-004 The block SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1: begin a run when sampled high in IDLE or DONE.
REQ-007 The block SHALL have port mode, input, 2: stimulus pattern, sampled on accepted start.
REQ-008 The block SHALL have port seed, input, WIDTH: initial operand, sampled on accepted start.
REQ-009 The block SHALL have port op, output, WIDTH: registered operand driven to DUT.
REQ-010 The block SHALL have port op_valid, output, 1: op holds a new vector this cycle.
REQ-011 The block SHALL have port dut_result, input, WIDTH: DUT output, valid LATENCY cycles after its op.
REQ-012 The block SHALL have port result_debug, output, WIDTH: last captured dut_result (mark_debug).
REQ-013 The block SHALL have port signature, output, WIDTH: MISR over captured results.
REQ-014 The block SHALL have port vec_count, output, clog2(N_VEC+1): vectors issued this run.
REQ-015 The block SHALL have ports busy and done, output, 1 each: run in progress; run complete.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DRAIN, DONE; busy=1 in RUN/DRAIN, done=1 only in DONE.
REQ-017 The block SHALL on start=1 in IDLE or DONE latch mode/seed, clear signature, vec_count, result_debug, and enter RUN next cycle.
REQ-018 The block SHALL ignore start while in RUN or DRAIN.
REQ-019 The block SHALL in RUN assert op_valid every cycle, issuing exactly N_VEC vectors on consecutive cycles, first vector on the first RUN cycle.
REQ-020 The block SHALL increment vec_count on each issued vector; after the N_VEC-th it SHALL enter DRAIN (or DONE directly when LATENCY=0 and the last result is captured that cycle).
REQ-021 The block SHALL hold op at its last value and op_valid=0 outside RUN.
REQ-022 The block SHALL for mode 0 (counter) issue seed, seed+1, ... modulo 2^WIDTH, wrapping silently.
REQ-023 The block SHALL for mode 1 (LFSR) issue start value seed, or 1 if seed==0; next = (x>>1) XOR (x[0] ? POLY : 0), POLY=32'hA3000000 for WIDTH=32 (maximal-length table per WIDTH).
REQ-024 The block SHALL for mode 2 (walking one) ignore seed, issue 1 first, then rotate left by one each vector, wrapping MSB to bit 0.
REQ-025 The block SHALL for mode 3 (hold) issue seed on every vector.
REQ-026 The block SHALL delay op_valid through a LATENCY-stage shift register; when the delayed valid is 1 it SHALL capture dut_result into result_debug and update signature = {signature[WIDTH-2:0], signature[WIDTH-1]} XOR dut_result.
REQ-027 The block SHALL remain in DRAIN until the N_VEC-th result is captured, then enter DONE the following cycle.
REQ-028 The block SHALL hold signature, result_debug, vec_count stable in DONE until next accepted start.
REQ-029 The block SHALL capture exactly N_VEC results per run, none outside the aligned window.

Reset
REQ-030 The block SHALL on reset=1 at any cycle, including mid-RUN/DRAIN, enter IDLE and zero op, op_valid, result_debug, signature, vec_count, busy, done, and the valid delay line.
REQ-031 The block SHALL give reset priority over start when both are high.

Verification
REQ-032 Bench SHALL run WIDTH=32, N_VEC=4, LATENCY=1, mode 0, seed 0, dut_result=op delayed 1 cycle -> op 0,1,2,3 on 4 consecutive cycles, signature=32'h3, result_debug=3, vec_count=4, done=1.
REQ-033 Bench SHALL run mode 1, seed 0 -> first op 32'h00000001, second op 32'hA3000000.
REQ-034 Bench SHALL run mode 2, N_VEC=33 -> ops 1,2,4,...,32'h80000000, then 33rd op 1.
REQ-035 Bench SHALL run mode 0, seed 32'hFFFFFFFE, N_VEC=3 -> ops FFFFFFFE, FFFFFFFF, 00000000 (wrap).
REQ-036 Bench SHALL assert reset on 2nd RUN cycle -> next cycle IDLE, all outputs 0; subsequent start yields a clean run identical to REQ-032.
REQ-037 Bench SHALL pulse start mid-RUN and during DONE -> mid-RUN ignored (exactly N_VEC vectors); in DONE a new run begins, signature restarts from 0.
